// File: rtl/pll_cfg_responder.sv
// Avalon-MM PLL reconfiguration responder: pending config registers are
// snapshotted on START and applied to act_* after a fixed busy period.
module pll_cfg_responder #(
    parameter int          NUM_C       = 3,
    parameter int          BUSY_CYCLES = 16,
    parameter logic [17:0] RST_N       = 18'h10000
) (
    input  logic                  mgmt_clk,
    input  logic                  reset,
    input  logic [5:0]            cfg_address,
    input  logic                  cfg_write,
    input  logic                  cfg_read,
    input  logic [31:0]           cfg_writedata,
    output logic                  cfg_waitrequest,
    output logic [31:0]           cfg_readdata,
    output logic                  cfg_readdatavalid,
    output logic [17:0]           act_n,
    output logic [17:0]           act_m,
    output logic [18*NUM_C-1:0]   act_c,
    output logic [31:0]           act_frac,
    output logic [3:0]            act_bw,
    output logic [2:0]            act_cp,
    output logic                  cfg_applied,
    output logic                  cfg_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [17:0]          n;
        logic [17:0]          m;
        logic [18*NUM_C-1:0]  c;
        logic [31:0]          frac;
        logic [3:0]           bw;
        logic [2:0]           cp;
    } cfg_t;

    localparam cfg_t CFG_RST = '{n: RST_N, m: '0, c: '0, frac: '0, bw: '0, cp: '0};

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic        wait_q, wait_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        applied_q, applied_d;
    logic        err_q, err_d;
    logic [4:0]  cidx_q, cidx_d;
    cfg_t        pend_q, pend_d;
    cfg_t        snap_q, snap_d;
    cfg_t        act_q, act_d;

    logic        wr_acc;
    logic        rd_acc;
    logic [4:0]  wr_cidx;
    logic [17:0] c_sel;

    assign wr_acc  = cfg_write && !wait_q;
    assign rd_acc  = cfg_read && !cfg_write && !wait_q;
    assign wr_cidx = cfg_writedata[22:18];

    always_comb begin
        c_sel = '0;
        for (int k = 0; k < NUM_C; k++) begin
            if (cidx_q == 5'(k)) begin
                c_sel = pend_q.c[18*k +: 18];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        applied_d = 1'b0;
        err_d     = 1'b0;
        cidx_d    = cidx_q;
        pend_d    = pend_q;
        snap_d    = snap_q;
        act_d     = act_q;

        // The snapshot taken at START is what gets applied, so pending writes
        // made during BUSY (polling mode) only affect the next reconfiguration.
        if (state_q == BUSY) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
                act_d     = snap_q;
                applied_d = 1'b1;
                state_d   = IDLE;
                cnt_d     = '0;
            end
        end

        if (wr_acc) begin
            if (cfg_read) begin
                err_d = 1'b1;
            end
            case (cfg_address)
                6'd0: mode_d = cfg_writedata[0];
                6'd1: ;
                6'd2: begin
                    if (state_q == IDLE) begin
                        state_d = BUSY;
                        cnt_d   = 8'(BUSY_CYCLES);
                        snap_d  = pend_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                6'd3: pend_d.n = cfg_writedata[17:0];
                6'd4: pend_d.m = cfg_writedata[17:0];
                6'd5: begin
                    if ({27'd0, wr_cidx} < 32'(NUM_C)) begin
                        for (int k = 0; k < NUM_C; k++) begin
                            if (wr_cidx == 5'(k)) begin
                                pend_d.c[18*k +: 18] = cfg_writedata[17:0];
                            end
                        end
                        cidx_d = wr_cidx;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                6'd7: pend_d.frac = cfg_writedata;
                6'd8: pend_d.bw   = cfg_writedata[3:0];
                6'd9: pend_d.cp   = cfg_writedata[2:0];
                default: err_d = 1'b1;
            endcase
        end

        if (rd_acc) begin
            rvalid_d = 1'b1;
            case (cfg_address)
                6'd0:    rdata_d = {31'd0, mode_q};
                6'd1:    rdata_d = {31'd0, state_q == IDLE};
                6'd3:    rdata_d = {14'd0, pend_q.n};
                6'd4:    rdata_d = {14'd0, pend_q.m};
                6'd5:    rdata_d = {14'd0, c_sel};
                6'd7:    rdata_d = pend_q.frac;
                6'd8:    rdata_d = {28'd0, pend_q.bw};
                6'd9:    rdata_d = {29'd0, pend_q.cp};
                default: rdata_d = '0;
            endcase
        end

        wait_d = (state_d == BUSY) && !mode_d;
    end

    always_ff @(posedge mgmt_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            wait_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            applied_q <= 1'b0;
            err_q     <= 1'b0;
            cidx_q    <= '0;
            pend_q    <= CFG_RST;
            snap_q    <= CFG_RST;
            act_q     <= CFG_RST;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            wait_q    <= wait_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            applied_q <= applied_d;
            err_q     <= err_d;
            cidx_q    <= cidx_d;
            pend_q    <= pend_d;
            snap_q    <= snap_d;
            act_q     <= act_d;
        end
    end

    assign cfg_waitrequest   = wait_q;
    assign cfg_readdata      = rdata_q;
    assign cfg_readdatavalid = rvalid_q;
    assign cfg_applied       = applied_q;
    assign cfg_err           = err_q;
    assign act_n             = act_q.n;
    assign act_m             = act_q.m;
    assign act_c             = act_q.c;
    assign act_frac          = act_q.frac;
    assign act_bw            = act_q.bw;
    assign act_cp            = act_q.cp;

endmodule

// File: tb/tb_pll_cfg_responder.sv
// Directed bench for pll_cfg_responder: inputs driven and outputs sampled on
// the falling edge of mgmt_clk.
module tb_pll_cfg_responder;

    logic        mgmt_clk = 1'b0;
    logic        reset;
    logic [5:0]  cfg_address;
    logic        cfg_write;
    logic        cfg_read;
    logic [31:0] cfg_writedata;
    logic        cfg_waitrequest;
    logic [31:0] cfg_readdata;
    logic        cfg_readdatavalid;
    logic [17:0] act_n;
    logic [17:0] act_m;
    logic [53:0] act_c;
    logic [31:0] act_frac;
    logic [3:0]  act_bw;
    logic [2:0]  act_cp;
    logic        cfg_applied;
    logic        cfg_err;

    int n_chk  = 0;
    int n_fail = 0;
    int elapsed;
    int wcnt;
    int pulses;

    always #5 mgmt_clk = ~mgmt_clk;

    pll_cfg_responder #(.NUM_C(3), .BUSY_CYCLES(16), .RST_N(18'h10000)) dut (
        .mgmt_clk          (mgmt_clk),
        .reset             (reset),
        .cfg_address       (cfg_address),
        .cfg_write         (cfg_write),
        .cfg_read          (cfg_read),
        .cfg_writedata     (cfg_writedata),
        .cfg_waitrequest   (cfg_waitrequest),
        .cfg_readdata      (cfg_readdata),
        .cfg_readdatavalid (cfg_readdatavalid),
        .act_n             (act_n),
        .act_m             (act_m),
        .act_c             (act_c),
        .act_frac          (act_frac),
        .act_bw            (act_bw),
        .act_cp            (act_cp),
        .cfg_applied       (cfg_applied),
        .cfg_err           (cfg_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Single-cycle write; returns on the next falling edge, where cfg_err reflects it.
    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        cfg_address   = a;
        cfg_writedata = d;
        cfg_write     = 1'b1;
        @(negedge mgmt_clk);
        cfg_write     = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
        cfg_address = a;
        cfg_read    = 1'b1;
        @(negedge mgmt_clk);
        cfg_read    = 1'b0;
        chk({tag, "_valid"}, 64'(cfg_readdatavalid), 64'd1);
        chk(tag, 64'(cfg_readdata), 64'(exp));
    endtask

    initial begin
        reset         = 1'b1;
        cfg_address   = '0;
        cfg_write     = 1'b0;
        cfg_read      = 1'b0;
        cfg_writedata = '0;
        repeat (2) @(negedge mgmt_clk);
        chk("rst_wait",    64'(cfg_waitrequest), 64'd0);
        chk("rst_rvalid",  64'(cfg_readdatavalid), 64'd0);
        chk("rst_rdata",   64'(cfg_readdata), 64'd0);
        chk("rst_applied", 64'(cfg_applied), 64'd0);
        chk("rst_err",     64'(cfg_err), 64'd0);
        chk("rst_act_n",   64'(act_n), 64'h10000);
        chk("rst_act_m",   64'(act_m), 64'd0);
        reset = 1'b0;
        @(negedge mgmt_clk);

        // Pending-only write
        wr(6'd4, 32'h20504);
        chk("m_wr_err", 64'(cfg_err), 64'd0);
        chk("m_no_apply", 64'(act_m), 64'd0);
        rd("rd_m_pend", 6'd4, 32'h00020504);

        // Full reconfiguration in waitrequest mode
        wr(6'd0, 32'd0);
        wr(6'd3, 32'h10000);
        wr(6'd4, 32'h00606);
        wr(6'd5, 32'h00505);
        wr(6'd5, 32'h40505);
        wr(6'd5, 32'h80A0A);
        wr(6'd7, 32'h9C766C6E);
        wr(6'd8, 32'd8);
        wr(6'd9, 32'd3);
        chk("pre_start_act_m", 64'(act_m), 64'd0);
        rd("rd_c_last", 6'd5, 32'h00A0A);
        wr(6'd2, 32'd0);
        elapsed = 1;
        wcnt    = 0;
        while (!cfg_applied && elapsed < 40) begin
            if (cfg_waitrequest) wcnt++;
            @(negedge mgmt_clk);
            elapsed++;
        end
        chk("apply_latency", 64'(elapsed), 64'd17);
        chk("wait_cycles",   64'(wcnt), 64'd16);
        chk("wait_at_apply", 64'(cfg_waitrequest), 64'd0);
        chk("act_n",    64'(act_n), 64'h10000);
        chk("act_m",    64'(act_m), 64'h00606);
        chk("act_c2",   64'(act_c[53:36]), 64'h00A0A);
        chk("act_c_all", 64'(act_c), {10'd0, 18'h00A0A, 18'h00505, 18'h00505});
        chk("act_frac", 64'(act_frac), 64'h9C766C6E);
        chk("act_bw",   64'(act_bw), 64'd8);
        chk("act_cp",   64'(act_cp), 64'd3);
        @(negedge mgmt_clk);
        chk("applied_one_cycle", 64'(cfg_applied), 64'd0);

        // Illegal accesses
        wr(6'd5, 32'h140303);
        chk("bad_cidx_err", 64'(cfg_err), 64'd1);
        wr(6'd12, 32'h1234);
        chk("addr12_err", 64'(cfg_err), 64'd1);
        wr(6'd6, 32'h1);
        chk("addr6_err", 64'(cfg_err), 64'd1);
        chk("act_c_kept", 64'(act_c), {10'd0, 18'h00A0A, 18'h00505, 18'h00505});
        rd("rd_c_kept", 6'd5, 32'h00A0A);
        rd("rd_m_kept", 6'd4, 32'h00606);
        rd("rd_frac_kept", 6'd7, 32'h9C766C6E);

        // Polling mode
        wr(6'd0, 32'd1);
        wr(6'd2, 32'd0);
        elapsed = 1;
        chk("poll_no_wait", 64'(cfg_waitrequest), 64'd0);
        rd("status_busy", 6'd1, 32'd0);
        elapsed++;
        wr(6'd2, 32'd0);
        elapsed++;
        chk("second_start_err", 64'(cfg_err), 64'd1);
        wr(6'd4, 32'h111);
        elapsed++;
        chk("busy_wr_err", 64'(cfg_err), 64'd0);
        while (!cfg_applied && elapsed < 40) begin
            @(negedge mgmt_clk);
            elapsed++;
        end
        chk("poll_latency", 64'(elapsed), 64'd17);
        chk("poll_act_m", 64'(act_m), 64'h00606);
        rd("rd_m_busy_wr", 6'd4, 32'h111);
        rd("status_idle", 6'd1, 32'd1);

        // Simultaneous read and write
        cfg_address   = 6'd8;
        cfg_writedata = 32'd5;
        cfg_write     = 1'b1;
        cfg_read      = 1'b1;
        @(negedge mgmt_clk);
        cfg_write = 1'b0;
        cfg_read  = 1'b0;
        chk("rw_err",    64'(cfg_err), 64'd1);
        chk("rw_rvalid", 64'(cfg_readdatavalid), 64'd0);
        rd("rd_bw_rw", 6'd8, 32'd5);

        // Reset mid-BUSY
        wr(6'd0, 32'd0);
        wr(6'd2, 32'd0);
        repeat (4) @(negedge mgmt_clk);
        chk("busy_wait_hi", 64'(cfg_waitrequest), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_wait", 64'(cfg_waitrequest), 64'd0);
        @(negedge mgmt_clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (cfg_applied) pulses++;
            @(negedge mgmt_clk);
        end
        chk("abort_no_applied", 64'(pulses), 64'd0);
        chk("abort_act_n", 64'(act_n), 64'h10000);
        chk("abort_act_m", 64'(act_m), 64'd0);
        chk("abort_wait",  64'(cfg_waitrequest), 64'd0);
        rd("rd_n_rst", 6'd3, 32'h10000);
        rd("rd_m_rst", 6'd4, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
